// File: rtl/mc_core_pkg.sv
// mc_core_pkg: ALU op encodings, instruction field positions and FSM states shared by mc_core
package mc_core_pkg;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_XOR  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLTS = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_EQ   = 5'd16;
    localparam logic [4:0] OP_NE   = 5'd17;
    localparam logic [4:0] OP_LTS  = 5'd18;
    localparam logic [4:0] OP_GES  = 5'd19;
    localparam logic [4:0] OP_LTU  = 5'd20;
    localparam logic [4:0] OP_GEU  = 5'd21;

    localparam int B_BIT   = 31;
    localparam int C_BIT   = 30;
    localparam int W_BIT   = 29;
    localparam int S_BIT   = 28;
    localparam int OP_LSB  = 23;
    localparam int RA1_LSB = 18;
    localparam int RA2_LSB = 13;
    localparam int OFF_LSB = 5;
    localparam int WA_LSB  = 0;
    localparam int K_MSB   = 27;
    localparam int K_LSB   = 5;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
endpackage

// File: rtl/mc_core_regfile.sv
// mc_core_regfile: 32 x DATA_W register file, two async read ports, one sync write port, x0 reads zero
module mc_core_regfile
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] mem [32];

    always_ff @(posedge CLK)
        if (we && wa != 5'd0) mem[wa] <= wd;

    assign rd1 = ra1 == 5'd0 ? '0 : mem[ra1];
    assign rd2 = ra2 == 5'd0 ? '0 : mem[ra2];
endmodule

// File: rtl/mc_core.sv
// mc_core: multicycle FETCH/DECODE/EXEC/WB core with IN handshake, strobed OUT and halt.
// Define MC_CORE_PERF_EN to add RETIRED_CNT/STALL_CNT performance counters.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [PC_W-1:0]   IM_ADDR,
    input  logic [31:0]       IM_DATA,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    output logic              HALTED
`ifdef MC_CORE_PERF_EN
    ,
    output logic [31:0]       RETIRED_CNT,
    output logic [31:0]       STALL_CNT
`endif
);
    localparam int SH_W = $clog2(DATA_W);

    state_t            state, state_nx;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1, rd2, rf_rd1, rf_rd2, alu_r, alu_nx, in_r, k_ext, wd;
    logic              flag_r, flag_nx;
    logic              b, c, w, s, is_in, is_out, halt_i, take;
    logic [4:0]        op;
    logic [SH_W-1:0]   sh;

    assign b      = ir[B_BIT];
    assign c      = ir[C_BIT];
    assign w      = ir[W_BIT];
    assign s      = ir[S_BIT];
    assign op     = ir[OP_LSB +: 5];
    assign is_in  = !w && s;
    assign is_out = !(w || s || b || c);
    assign halt_i = b && ir[OFF_LSB +: 8] == 8'd0;
    assign take   = b || (c && flag_r);
    assign k_ext  = DATA_W'($signed(ir[K_MSB:K_LSB]));
    assign sh     = rd2[SH_W-1:0];
    assign wd     = w ? (s ? alu_r : k_ext) : in_r;

    assign IM_ADDR  = pc;
    assign IN_READY = state == EXEC && is_in;
    assign HALTED   = state == HALT;

    // Operand addresses come straight off the ROM bus so the read lands in DECODE
    mc_core_regfile #(.DATA_W(DATA_W)) u_rf (
        .CLK (CLK),
        .we  (state == WB && (w || s)),
        .wa  (ir[WA_LSB +: 5]),
        .wd  (wd),
        .ra1 (IM_DATA[RA1_LSB +: 5]),
        .ra2 (IM_DATA[RA2_LSB +: 5]),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    always_comb begin
        alu_nx  = '0;
        flag_nx = 1'b0;
        case (op)
            OP_ADD:  alu_nx = rd1 + rd2;
            OP_SUB:  alu_nx = rd1 - rd2;
            OP_XOR:  alu_nx = rd1 ^ rd2;
            OP_OR:   alu_nx = rd1 | rd2;
            OP_AND:  alu_nx = rd1 & rd2;
            OP_SLL:  alu_nx = rd1 << sh;
            OP_SRL:  alu_nx = rd1 >> sh;
            OP_SRA:  alu_nx = $signed(rd1) >>> sh;
            OP_SLTS: alu_nx = DATA_W'($signed(rd1) < $signed(rd2));
            OP_SLTU: alu_nx = DATA_W'(rd1 < rd2);
            OP_EQ:   flag_nx = rd1 == rd2;
            OP_NE:   flag_nx = rd1 != rd2;
            OP_LTS:  flag_nx = $signed(rd1) < $signed(rd2);
            OP_GES:  flag_nx = $signed(rd1) >= $signed(rd2);
            OP_LTU:  flag_nx = rd1 < rd2;
            OP_GEU:  flag_nx = rd1 >= rd2;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = DECODE;
            DECODE:  state_nx = EXEC;
            EXEC:    state_nx = (!is_in || IN_VALID) ? WB : EXEC;
            WB:      state_nx = halt_i ? HALT : FETCH;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            state     <= state_nx;
            OUT_VALID <= state == WB && is_out;
            if (state == DECODE) begin
                ir  <= IM_DATA;
                rd1 <= rf_rd1;
                rd2 <= rf_rd2;
            end
            if (state == EXEC) begin
                alu_r  <= alu_nx;
                flag_r <= flag_nx;
            end
            if (IN_READY && IN_VALID) in_r <= IN_DATA;
            if (state == WB) begin
                pc <= take ? pc + PC_W'($signed(ir[OFF_LSB +: 8])) : pc + PC_W'(1);
                if (is_out) OUT_DATA <= rd1;
            end
        end
    end

`ifdef MC_CORE_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RETIRED_CNT <= '0;
            STALL_CNT   <= '0;
        end else begin
            if (state == WB) RETIRED_CNT <= RETIRED_CNT + 32'd1;
            if (IN_READY && !IN_VALID) STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed programs for 32- and 16-bit cores; OUT scoreboard, PC trace, handshake and halt checks
`timescale 1ns/1ps
module tb_mc_core;
    import mc_core_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  im_addr, im_addr16;
    logic [31:0] im_data, im_data16;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, out_valid, halted;
    logic [31:0] out_data;
    logic        in_ready16, out_valid16, halted16;
    logic [15:0] out_data16;
    logic [31:0] rom   [256];
    logic [31:0] rom16 [256];
`ifdef MC_CORE_PERF_EN
    logic [31:0] retired, stall, retired16, stall16;
`endif

    int          vectors = 0, miscompares = 0, cyc = 0;
    int          rel_cyc, last_chg, rdy_cnt;
    logic [7:0]  prev_addr;
    bit          armed, first_out;
    logic [31:0] exp_q[$];
    logic [15:0] exp16_q[$];
    logic [7:0]  pc_q[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc       <= cyc + 1;
        im_data   <= rom[im_addr];
        im_data16 <= rom16[im_addr16];
    end

    mc_core dut (
        .CLK(CLK), .RST(RST), .IM_ADDR(im_addr), .IM_DATA(im_data),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .HALTED(halted)
`ifdef MC_CORE_PERF_EN
        , .RETIRED_CNT(retired), .STALL_CNT(stall)
`endif
    );

    mc_core #(.DATA_W(16), .PC_W(8)) dut16 (
        .CLK(CLK), .RST(RST), .IM_ADDR(im_addr16), .IM_DATA(im_data16),
        .IN_DATA(16'h0000), .IN_VALID(1'b0), .IN_READY(in_ready16),
        .OUT_DATA(out_data16), .OUT_VALID(out_valid16), .HALTED(halted16)
`ifdef MC_CORE_PERF_EN
        , .RETIRED_CNT(retired16), .STALL_CNT(stall16)
`endif
    );

    function automatic logic [31:0] i_k(logic [4:0] wa, logic [22:0] k);
        return {4'b0010, k, wa};
    endfunction
    function automatic logic [31:0] i_alu(logic [4:0] op, logic [4:0] ra1, logic [4:0] ra2, logic [4:0] wa);
        return {4'b0011, op, ra1, ra2, 8'h00, wa};
    endfunction
    function automatic logic [31:0] i_out(logic [4:0] ra1);
        return {4'b0000, 5'd0, ra1, 5'd0, 8'h00, 5'd0};
    endfunction
    function automatic logic [31:0] i_in(logic [4:0] wa);
        return {4'b0001, 23'd0, wa};
    endfunction
    function automatic logic [31:0] i_br(logic bb, logic cc, logic [4:0] op, logic [4:0] ra1, logic [4:0] ra2, logic [7:0] off);
        return {bb, cc, 2'b00, op, ra1, ra2, off, 5'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic miss(input string nm, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h, expected nothing (cycle %0d)", nm, act, cyc);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            rom[i]   = '0;
            rom16[i] = '0;
        end
        rom[0]   = i_k(5'd3, 23'h7ffffb);          exp_q.push_back(32'hffff_fffb);
        rom[1]   = i_out(5'd3);
        rom[2]   = i_k(5'd1, 23'd7);
        rom[3]   = i_k(5'd2, 23'd3);
        rom[4]   = i_alu(OP_SUB, 5'd1, 5'd2, 5'd4);   exp_q.push_back(32'd4);
        rom[5]   = i_out(5'd4);
        rom[6]   = i_k(5'd5, 23'h7ffff0);
        rom[7]   = i_k(5'd6, 23'd2);
        rom[8]   = i_alu(OP_SRA, 5'd5, 5'd6, 5'd7);   exp_q.push_back(32'hffff_fffc);
        rom[9]   = i_out(5'd7);
        rom[10]  = i_k(5'd0, 23'd99);                 exp_q.push_back(32'd0);
        rom[11]  = i_out(5'd0);
        rom[12]  = i_alu(OP_ADD, 5'd1, 5'd2, 5'd8);   exp_q.push_back(32'd10);
        rom[13]  = i_out(5'd8);
        rom[14]  = i_alu(OP_SLTS, 5'd5, 5'd1, 5'd9);  exp_q.push_back(32'd1);
        rom[15]  = i_out(5'd9);
        rom[16]  = i_alu(OP_SLTU, 5'd5, 5'd1, 5'd10); exp_q.push_back(32'd0);
        rom[17]  = i_out(5'd10);
        rom[18]  = i_in(5'd11);                       exp_q.push_back(32'h55);
        rom[19]  = i_out(5'd11);
        rom[20]  = i_k(5'd12, 23'd1);
        rom[21]  = i_k(5'd13, 23'd2);
        rom[22]  = i_br(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 8'd4);
        rom[23]  = i_k(5'd12, 23'd2);                 exp_q.push_back(32'd2);
        rom[24]  = i_out(5'd12);
        rom[25]  = i_alu(OP_ADD, 5'd0, 5'd0, 5'd0);
        rom[26]  = i_br(1'b0, 1'b1, OP_LTU, 5'd12, 5'd13, 8'hfd);
        rom[27]  = i_out(5'd13);                      exp_q.push_back(32'd2);
        rom[28]  = i_br(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 8'he3);
        rom[255] = i_out(5'd13);                      exp_q.push_back(32'd2);
        exp_q.push_back(32'hffff_fffb);
        for (int a = 1; a <= 22; a++) pc_q.push_back(8'(a));
        pc_q.push_back(8'd26); pc_q.push_back(8'd23); pc_q.push_back(8'd24); pc_q.push_back(8'd25);
        pc_q.push_back(8'd26); pc_q.push_back(8'd27); pc_q.push_back(8'd28); pc_q.push_back(8'd255);
        pc_q.push_back(8'd0);  pc_q.push_back(8'd1);  pc_q.push_back(8'd2);

        rom16[0] = i_k(5'd1, 23'h7fffff);
        rom16[1] = i_k(5'd2, 23'd1);
        rom16[2] = i_alu(OP_ADD, 5'd1, 5'd2, 5'd3);
        rom16[3] = i_out(5'd3);                       exp16_q.push_back(16'h0000);
        rom16[4] = i_k(5'd4, 23'h012345);
        rom16[5] = i_out(5'd4);                       exp16_q.push_back(16'h2345);
        rom16[6] = i_br(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0);

        fork
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (armed) begin
                        if (out_valid) begin
                            if (!first_out) begin
                                first_out = 1'b1;
                                chk("out_latency", 32'(cyc - rel_cyc), 32'd8);
                            end
                            if (exp_q.size() == 0) miss("out_extra", out_data);
                            else chk("out_data", out_data, exp_q.pop_front());
                        end
                        if (out_valid16) begin
                            if (exp16_q.size() == 0) miss("out16_extra", 32'(out_data16));
                            else chk("out16_data", 32'(out_data16), 32'(exp16_q.pop_front()));
                        end
                        if (im_addr != prev_addr) begin
                            if (pc_q.size() == 0) miss("pc_extra", 32'(im_addr));
                            else chk("pc_trace", 32'(im_addr), 32'(pc_q.pop_front()));
                            if (prev_addr != 8'd18) chk("instr_latency", 32'(cyc - last_chg), 32'd4);
                            last_chg  = cyc;
                            prev_addr = im_addr;
                        end
                        if (in_ready) rdy_cnt++;
                    end
                end
            end
            begin : stimulus
                repeat (3) @(negedge CLK);
                chk("rst_im_addr", 32'(im_addr), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_data", out_data, 32'd0);
                chk("rst_halted", 32'(halted), 32'd0);
`ifdef MC_CORE_PERF_EN
                chk("rst_retired", retired, 32'd0);
                chk("rst_stall", stall, 32'd0);
`endif
                RST = 1'b0;
                repeat (6) @(negedge CLK);
                chk("prerst_pc", 32'(im_addr), 32'd1);
                RST = 1'b1;
                @(negedge CLK);
                chk("midrst_pc", 32'(im_addr), 32'd0);
                chk("midrst_out_valid", 32'(out_valid), 32'd0);
                RST       = 1'b0;
                rel_cyc   = cyc;
                last_chg  = cyc;
                prev_addr = 8'd0;
                armed     = 1'b1;
                in_valid  = 1'b1;
                in_data   = 32'haa;
                repeat (20) @(negedge CLK);
                in_valid  = 1'b0;
                in_data   = '0;
                n = 0;
                while (!in_ready && n < 400) begin
                    @(negedge CLK);
                    n++;
                end
                if (!in_ready) miss("in_ready_timeout", 32'(n));
                else begin
                    rom[2] = i_br(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0);
                    repeat (10) @(negedge CLK);
                    in_valid = 1'b1;
                    in_data  = 32'h55;
                    @(negedge CLK);
                    in_valid = 1'b0;
                    in_data  = '0;
`ifdef MC_CORE_PERF_EN
                    chk("stall_cnt", stall, 32'd10);
`endif
                end
                n = 0;
                while (!halted && n < 2000) begin
                    @(negedge CLK);
                    n++;
                end
                chk("halted", 32'(halted), 32'd1);
                for (int i = 0; i < 20; i++) begin
                    @(negedge CLK);
                    chk("halt_addr", 32'(im_addr), 32'd2);
                end
                chk("out_hold", out_data, 32'hffff_fffb);
                chk("in_ready_cycles", 32'(rdy_cnt), 32'd11);
                chk("halted16", 32'(halted16), 32'd1);
                chk("in_ready16", 32'(in_ready16), 32'd0);
`ifdef MC_CORE_PERF_EN
                chk("retired_cnt", retired, 32'd34);
                chk("retired16_cnt", retired16, 32'd7);
`endif
                armed = 1'b0;
                chk("out_left", 32'(exp_q.size()), 32'd0);
                chk("out16_left", 32'(exp16_q.size()), 32'd0);
                chk("pc_left", 32'(pc_q.size()), 32'd0);
                RST = 1'b1;
                @(negedge CLK);
                chk("rst_clears_halted", 32'(halted), 32'd0);
                chk("rst_clears_pc", 32'(im_addr), 32'd0);
`ifdef MC_CORE_PERF_EN
                chk("rst_clears_retired", retired, 32'd0);
`endif
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multicycle successor to the team's single-cycle core.
- Same 32-bit instruction encoding, with these additions:
  - configurable data and PC width;
  - explicit fetch/decode/execute/writeback FSM;
  - valid/ready handshake on the input port;
  - strobed output port and a halt state;
  - register x0 hardwired to zero.
- Sits between an external synchronous instruction ROM and the board-level I/O.

Parameters:
- DATA_W, 32, datapath and register width. Must be >= 8.
- PC_W, 8, program counter and ROM address width. Must be >= 8.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- IM_ADDR  out  PC_W  instruction ROM address (equals PC).
- IM_DATA  in  32  ROM read data, valid one cycle after IM_ADDR.
- IN_DATA  in  DATA_W  external input word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  core accepting IN_DATA.
- OUT_DATA  out  DATA_W  last emitted value.
- OUT_VALID  out  1  one-cycle strobe, new OUT_DATA.
- HALTED  out  1  core stopped.

Behaviour:
- Single clock CLK; RST is synchronous, active-high, and overrides everything including mid-instruction.
- Reset values: PC=0, state FETCH, IN_READY=0, OUT_VALID=0, OUT_DATA=0, HALTED=0. Register file contents are not reset.
- Instruction fields:
  - [31] B = unconditional jump
  - [30] C = conditional jump
  - [29] W, [28] S = write-source select
  - [27:23] ALUOp
  - [22:18] RA1, [17:13] RA2
  - [12:5] OFF = signed 8-bit PC offset
  - [4:0] WA = write address
  - [27:5] K = 23-bit constant, sign-extended (truncated if DATA_W < 23)
- Write source, by W,S:
  - W,S=1,1: ALU result
  - W,S=1,0: K
  - W,S=0,1: IN_DATA (with handshake)
  - W,S=0,0: no register write
- FSM states and per-state actions:
  - FETCH: drive IM_ADDR=PC.
  - DECODE: latch IM_DATA into IR; read RD1=RF[RA1], RD2=RF[RA2].
  - EXEC: compute ALU result and flag.
  - WB: write RF[WA] if enabled; update PC; go to FETCH.
- Instruction latency: every instruction takes exactly 4 cycles, except an IN instruction waiting for input.
- IN instruction (W=0,S=1):
  - IN_READY=1 only while in EXEC.
  - Core stays in EXEC until IN_VALID & IN_READY, then captures IN_DATA and goes to WB.
  - IN_VALID asserted outside EXEC is ignored.
- OUT instruction (W,S,B,C all 0):
  - In WB, OUT_DATA <= RD1 and OUT_VALID=1 for exactly one cycle.
  - OUT_DATA holds until the next OUT instruction.
- PC update:
  - If B | (C & flag): PC <= PC + sext(OFF), modulo 2^PC_W.
  - Otherwise PC <= PC + 1, also wrapping.
- Halt: B=1 with OFF=0 moves the core to state HALT. HALTED=1, the FSM is frozen, and only RST exits.
- ALU ops:
  - ADD, SUB, XOR, OR, AND, SLTS, SLTU produce a DATA_W result with the flag=0.
  - SLL, SRL, SRA shift by the low clog2(DATA_W) bits of RD2.
  - Comparisons EQ, NE, LTS, GES, LTU, GEU produce result 0 and set the flag.
  - Undefined op gives result 0, flag 0.
  - Overflow wraps silently.
- Register x0: reads 0 and ignores writes.
- Read/write ordering: RF reads happen in DECODE, so a write in WB is always visible to the next instruction. No bypass is needed.
- Simultaneous events: RST during an EXEC IN-wait drops IN_READY in the following cycle; no write occurs.

Optional Feature:
- Macro: MC_CORE_PERF_EN.
- When defined, adds two outputs:
  - RETIRED_CNT [31:0]: increments once per WB.
  - STALL_CNT [31:0]: increments for each EXEC cycle spent waiting on IN_VALID.
- Both counters reset to 0 on RST, wrap at 2^32, and freeze while HALTED.
- When undefined, neither port nor counter logic exists. All other behaviour is identical.

Decomposition:
- Package mc_core_pkg holds:
  - ALUOp encodings, 5-bit localparams: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLTS=8, SLTU=9, EQ=16, NE=17, LTS=18, GES=19, LTU=20, GEU=21;
  - instruction field bit positions;
  - the FSM state enum: FETCH, DECODE, EXEC, WB, HALT.
- Sub-module mc_core_regfile: 32 x DATA_W, two combinational read ports, one synchronous write port, x0 forced to zero.
- ALU stays inline in mc_core.

Test Plan:
- Reset and constant load:
  - Stimulus: RST mid-run, then load K=-5 (W,S=1,0) into x3, then OUT x3.
  - Required: OUT_DATA=0xFFFFFFFB, with OUT_VALID pulsing once 8 cycles after reset release.
- ALU and x0:
  - Stimulus: x1=7, x2=3; SUB x4; SRA of -16 by 2; write to x0, then OUT x0.
  - Required: results 4 and -4; OUT of x0 gives 0.
- IN handshake stall:
  - Stimulus: IN instruction with IN_VALID held low for 10 cycles, then IN_DATA=0x55 for one cycle.
  - Required: IN_READY stays high for 11 cycles; register = 0x55; STALL_CNT=10 when MC_CORE_PERF_EN is defined.
- Conditional branch:
  - Stimulus: LTU with x1=1, x2=2, C=1, OFF=-3.
  - Required: PC decrements by 3.
  - Stimulus: same with x1=2.
  - Required: PC+1.
- PC wrap and halt:
  - Stimulus: PC=255 (PC_W=8) with a non-branch instruction.
  - Required: next PC=0.
  - Stimulus: B=1, OFF=0.
  - Required: HALTED=1; IM_ADDR is constant for 20 cycles; RST clears HALTED.
- Width parameter:
  - Stimulus: DATA_W=16 instance; ADD 0xFFFF+1.
  - Required: result 0x0000.
